// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped BTB with 2-bit saturating counters,
// trained from EX-stage resolution; also flags mispredictions and counts them.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned TAG_W   = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      if_pc,
  output logic             pred_taken,
  output logic [63:0]      pred_target,
  input  logic             upd_valid,
  input  logic [63:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [63:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic [63:0]      upd_pred_target,
  output logic             mispredict,
  output logic [63:0]      redirect_pc,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int unsigned TagLo = IDX_W + 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [63:0]        tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q;

  logic [IDX_W-1:0] if_idx, upd_idx;
  logic [TAG_W-1:0] if_tag, upd_tag;
  logic             if_hit, upd_hit, upd_we;
  logic [1:0]       upd_ctr_d;
  logic [63:0]      upd_tgt_d;

  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[TagLo +: TAG_W];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[TagLo +: TAG_W];

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  always_comb begin
    if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = if_hit && ctr_q[if_idx][1];
    pred_target = pred_taken ? tgt_q[if_idx] : if_pc + 64'd4;
  end

  always_comb begin
    upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_we    = upd_valid && (upd_hit || upd_taken) && !rst;
    upd_tgt_d = upd_taken ? upd_target : tgt_q[upd_idx];
    upd_ctr_d = ctr_q[upd_idx];
    if (!upd_hit) begin
      upd_ctr_d = 2'b10;
    end else if (upd_taken) begin
      if (ctr_q[upd_idx] != 2'b11) upd_ctr_d = ctr_q[upd_idx] + 2'b01;
    end else begin
      if (ctr_q[upd_idx] != 2'b00) upd_ctr_d = ctr_q[upd_idx] - 2'b01;
    end
  end

  always_comb begin
    mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                  (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
    redirect_pc = upd_taken ? upd_target : upd_pc + 64'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b01;
      end
    end else begin
      if (mispredict) cnt_q <= cnt_q + CNT_W'(1);
      if (upd_we) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= upd_ctr_d;
      end
    end
  end

  // Tags and targets need no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (upd_we) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= upd_tgt_d;
    end
  end

  assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: vector table, directed sequences
// and randomized traffic against an array-based reference model.
module tb_branch_predictor;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned TAG_W   = 16;
  localparam int unsigned CNT_W   = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [63:0]      if_pc = '0;
  logic             pred_taken;
  logic [63:0]      pred_target;
  logic             upd_valid = 1'b0;
  logic [63:0]      upd_pc = '0;
  logic             upd_taken = 1'b0;
  logic [63:0]      upd_target = '0;
  logic             upd_pred_taken = 1'b0;
  logic [63:0]      upd_pred_target = '0;
  logic             mispredict;
  logic [63:0]      redirect_pc;
  logic [CNT_W-1:0] mispredict_count;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  bit          m_valid [ENTRIES];
  logic [63:0] m_tag   [ENTRIES];
  logic [63:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  branch_predictor #(
    .ENTRIES(ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .mispredict_count(mispredict_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_idx(input logic [63:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [63:0] m_tagof(input logic [63:0] pc);
    return (pc >> (IDX_W + 2)) & ((64'd1 << TAG_W) - 64'd1);
  endfunction

  function automatic bit m_hit(input logic [63:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
  endfunction

  function automatic bit m_exp_mis();
    if (!upd_valid) return 1'b0;
    if (upd_taken != upd_pred_taken) return 1'b1;
    return upd_taken && (upd_target != upd_pred_target);
  endfunction

  // Compare all outputs with the model while inputs are stable.
  task automatic settle_check();
    bit          t;
    logic [63:0] tg;
    @(negedge clk);
    t  = m_hit(if_pc) && (m_ctr[m_idx(if_pc)] >= 2);
    tg = t ? m_tgt[m_idx(if_pc)] : if_pc + 64'd4;
    chk("pred_taken", 64'(pred_taken), 64'(t));
    chk("pred_target", pred_target, tg);
    chk("mispredict", 64'(mispredict), 64'(m_exp_mis()));
    if (m_exp_mis()) chk("redirect_pc", redirect_pc, upd_taken ? upd_target : upd_pc + 64'd4);
    chk("mispredict_count", 64'(mispredict_count), 64'(m_cnt));
  endtask

  task automatic edge_step();
    int i;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < int'(ENTRIES); k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 1;
      end
      m_cnt = '0;
    end else begin
      if (m_exp_mis()) m_cnt = m_cnt + 32'd1;
      if (upd_valid) begin
        i = m_idx(upd_pc);
        if (m_hit(upd_pc)) begin
          if (upd_taken) begin
            m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            m_tgt[i] = upd_target;
          end else begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
          end
        end else if (upd_taken) begin
          m_valid[i] = 1'b1;
          m_tag[i]   = m_tagof(upd_pc);
          m_tgt[i]   = upd_target;
          m_ctr[i]   = 2;
        end
      end
    end
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [63:0] pc, input logic t,
                         input logic [63:0] tg, input logic pt, input logic [63:0] ptg);
    upd_valid = v; upd_pc = pc; upd_taken = t; upd_target = tg;
    upd_pred_taken = pt; upd_pred_target = ptg;
  endtask

  typedef struct {
    logic        v, t, pt;
    logic [63:0] pc, tgt, ptgt;
    logic        exp_m;
    logic [63:0] exp_r;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 64'h1000, 64'h2000, 64'h0,    1'b0, 64'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 64'h1000, 64'h2000, 64'h0,    1'b1, 64'h2000};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 64'h1000, 64'h2000, 64'h2000, 1'b1, 64'h1004};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 64'h1000, 64'h2000, 64'h2000, 1'b0, 64'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 64'h1000, 64'h2400, 64'h2000, 1'b1, 64'h2400};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 64'h1000, 64'h2400, 64'h2000, 1'b0, 64'h0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 64'h40, 1'b1, 64'h0};

    // Initial reset, nothing to compare yet
    rst = 1'b1;
    edge_step();

    // Mispredict decode vectors, applied under reset so tables stay untouched
    foreach (vecs[j]) begin
      set_upd(vecs[j].v, vecs[j].pc, vecs[j].t, vecs[j].tgt, vecs[j].pt, vecs[j].ptgt);
      @(negedge clk);
      chk("vec_mispredict", 64'(mispredict), 64'(vecs[j].exp_m));
      if (vecs[j].exp_m) chk("vec_redirect", redirect_pc, vecs[j].exp_r);
      edge_step();
    end

    // Reset state
    rst = 1'b0;
    set_upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    if_pc = 64'h1000;
    settle_check();
    chk("reset_pred_taken", 64'(pred_taken), 64'd0);
    chk("reset_pred_target", pred_target, 64'h1004);
    chk("reset_count", 64'(mispredict_count), 64'd0);
    edge_step();

    // First taken resolution allocates
    set_upd(1'b1, 64'h1000, 1'b1, 64'h2000, 1'b0, 64'h0);
    settle_check();
    chk("alloc_mispredict", 64'(mispredict), 64'd1);
    chk("alloc_redirect", redirect_pc, 64'h2000);
    edge_step();
    set_upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    settle_check();
    chk("alloc_count", 64'(mispredict_count), 64'd1);
    chk("alloc_pred_taken", 64'(pred_taken), 64'd1);
    chk("alloc_pred_target", pred_target, 64'h2000);
    edge_step();

    // Saturate, then two not-taken: 11 -> 10 -> 01
    for (int k = 0; k < 3; k++) begin
      set_upd(1'b1, 64'h1000, 1'b1, 64'h2000, 1'b1, 64'h2000);
      settle_check();
      edge_step();
    end
    for (int k = 0; k < 2; k++) begin
      set_upd(1'b1, 64'h1000, 1'b0, 64'h2000, 1'b1, 64'h2000);
      settle_check();
      edge_step();
      set_upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
      settle_check();
      chk("hyst_pred_taken", 64'(pred_taken), (k == 0) ? 64'd1 : 64'd0);
      edge_step();
    end
    chk("hyst_count", 64'(mispredict_count), 64'd3);

    // Aliasing at index 0
    set_upd(1'b1, 64'h1000, 1'b1, 64'h2000, 1'b0, 64'h0);
    settle_check();
    edge_step();
    set_upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    if_pc = 64'h1040;
    settle_check();
    chk("alias_miss", 64'(pred_taken), 64'd0);
    edge_step();
    set_upd(1'b1, 64'h1040, 1'b1, 64'h5000, 1'b0, 64'h0);
    settle_check();
    edge_step();
    set_upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    settle_check();
    chk("alias_new_target", pred_target, 64'h5000);
    edge_step();
    if_pc = 64'h1000;
    settle_check();
    chk("alias_evicted", 64'(pred_taken), 64'd0);
    edge_step();

    // Same-cycle lookup and allocate
    if_pc = 64'h3000;
    set_upd(1'b1, 64'h3000, 1'b1, 64'h3100, 1'b0, 64'h0);
    settle_check();
    chk("rbw_old", 64'(pred_taken), 64'd0);
    edge_step();
    set_upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    settle_check();
    chk("rbw_new", 64'(pred_taken), 64'd1);
    chk("rbw_target", pred_target, 64'h3100);
    edge_step();

    // Wrong target with reset in the same cycle
    rst = 1'b1;
    set_upd(1'b1, 64'h1000, 1'b1, 64'h2400, 1'b1, 64'h2000);
    settle_check();
    chk("wt_mispredict", 64'(mispredict), 64'd1);
    chk("wt_redirect", redirect_pc, 64'h2400);
    edge_step();
    rst = 1'b0;
    set_upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    foreach (vecs[j]) begin
      if (j < 3) begin
        if_pc = (j == 0) ? 64'h1000 : (j == 1) ? 64'h1040 : 64'h3000;
        settle_check();
        chk("rst_cleared", 64'(pred_taken), 64'd0);
        chk("rst_count", 64'(mispredict_count), 64'd0);
        edge_step();
      end
    end

    // Randomized traffic over a small address pool to get hits and aliases
    for (int k = 0; k < 3000; k++) begin
      logic [63:0] pa, pb;
      bit          t;
      pa = (64'($urandom_range(0, 127)) << 2) | 64'($urandom_range(0, 3));
      pb = (64'($urandom_range(0, 127)) << 2) | 64'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) pb = pb | 64'hABCD_0000_0000_0000;
      if_pc = pa;
      rst   = ($urandom_range(0, 199) == 0);
      t     = m_hit(pb) && (m_ctr[m_idx(pb)] >= 2);
      set_upd($urandom_range(0, 9) < 7, pb, 1'($urandom_range(0, 1)),
              64'($urandom_range(0, 7)) << 4,
              ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : t,
              t ? m_tgt[m_idx(pb)] : 64'($urandom_range(0, 7)) << 4);
      settle_check();
      edge_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-stage branch predictor: direct-mapped BTB plus a 2-bit saturating-counter BHT.
- Supplies a next-PC prediction for the fetch PC.
- Consumes EX-stage branch resolution (the taken/not-taken decision and target) to train the tables.
- Flags a misprediction so the pipeline can flush and redirect.

Parameters:
- ENTRIES, 16, number of table entries (power of two, ≥2).
- IDX_W, 4, log2(ENTRIES).
- TAG_W, 16, tag bits taken from pc[IDX_W+2+TAG_W-1 : IDX_W+2].
- CNT_W, 32, width of the misprediction statistics counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- if_pc  input  64  fetch PC to predict.
- pred_taken  output  1  predicted taken (combinational from if_pc).
- pred_target  output  64  predicted target; equals if_pc+4 when pred_taken=0.
- upd_valid  input  1  EX stage resolving a conditional branch this cycle.
- upd_pc  input  64  PC of the resolving branch.
- upd_taken  input  1  actual branch outcome from the EX branch comparator.
- upd_target  input  64  actual taken target (PC+imm).
- upd_pred_taken  input  1  prediction carried down the pipe with the branch.
- upd_pred_target  input  64  predicted target carried down the pipe.
- mispredict  output  1  combinational: upd_valid and the prediction was wrong.
- redirect_pc  output  64  correct next PC: upd_target if upd_taken, else upd_pc+4.
- mispredict_count  output  CNT_W  registered count of mispredictions.

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+2+TAG_W-1 : IDX_W+2]; pc[1:0] ignored.
- Per entry: valid (1b), tag (TAG_W), target (64), ctr (2b).
  - ctr states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup:
  - hit = valid[idx] && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? target[idx] : if_pc+4 (64-bit wrap-around, carry discarded).
- Update on a rising edge with upd_valid=1, using the upd_pc index and tag:
  - Hit, upd_taken=1: ctr = min(ctr+1, 11); target = upd_target.
  - Hit, upd_taken=0: ctr = max(ctr-1, 00); target unchanged.
  - Miss, upd_taken=1: allocate (overwrite any previous occupant): valid=1, tag written, target=upd_target, ctr=10.
  - Miss, upd_taken=0: no table change.
  - upd_valid=0: no table change.
- Mispredict logic:
  - mispredict = upd_valid && ((upd_taken != upd_pred_taken) || (upd_taken && upd_pred_taken && upd_target != upd_pred_target)).
  - redirect_pc is valid whenever mispredict=1.
  - mispredict_count increments on each clock edge where mispredict=1; it wraps from all-ones to 0.
- Same cycle lookup and update to the same index: lookup returns the pre-update contents; the new contents are visible from the next cycle (read-before-write).
- Reset (synchronous, including mid-operation):
  - All valid=0, all ctr=01, tags/targets don't-care, mispredict_count=0.
  - After reset: pred_taken=0, pred_target=if_pc+4.
  - An upd_valid asserted in the same cycle as rst is ignored.
- mispredict and redirect_pc are combinational from the upd_* inputs and are not gated by rst.
- Aliasing: a differing tag at the same index is a miss; there is no associativity.

Test Plan:
- Reset, then if_pc=0x1000 -> pred_taken=0, pred_target=0x1004, mispredict_count=0.
- upd_valid, upd_pc=0x1000, taken=1, target=0x2000, pred_taken=0 -> mispredict=1, redirect_pc=0x2000, count=1; next cycle if_pc=0x1000 -> pred_taken=1, pred_target=0x2000.
- Train 0x1000 taken 3 more times (ctr saturates at 11), then not-taken twice -> ctr 11→10→01; prediction after the first not-taken is still taken, after the second it is not-taken.
- Alias: upd_pc=0x1000 allocated, then lookup 0x1040 (same index for ENTRIES=16, different tag) -> pred_taken=0; taken update at 0x1040 replaces the entry, after which 0x1000 misses.
- Same cycle: update allocates 0x3000 while if_pc=0x3000 -> pred_taken=0 that cycle, 1 the following cycle.
- Taken with wrong target: pred_taken=1, pred_target=0x2000, actual target 0x2400 -> mispredict=1, redirect_pc=0x2400; rst asserted alongside upd_valid -> tables cleared and the update is ignored.
